// File: rtl/node_info_ctrl.sv
// Node state for a clustered WSN node: hop count, CH role, TDMA slot, HB lock, low-energy flag
// and a multi-cycle Q-value divider. Optional CH role timeout: define NODEINFO_ROLE_TIMEOUT_EN.
module node_info_ctrl #(
    parameter int           W            = 16,
    parameter logic [W-1:0] NODE_ID      = 16'h000C,
    parameter logic [W-1:0] HYST         = 16'd8,
    parameter int           HB_TIMEOUT   = 1024,
    parameter int           ROLE_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [2:0]   pkt_type,
    input  logic [W-1:0] e_max,
    input  logic [W-1:0] e_min,
    input  logic [W-1:0] e_threshold,
    input  logic [W-1:0] energy,
    input  logic [W-1:0] ch_id,
    input  logic [W-1:0] hops,
    input  logic [W-1:0] timeslot,
    input  logic         q_start,
    output logic [W-1:0] my_node_id,
    output logic [W-1:0] hops_from_sink,
    output logic [W-1:0] timeslot_o,
    output logic [W-1:0] my_q_value,
    output logic         q_busy,
    output logic         q_valid,
    output logic         role,
    output logic         low_e,
    output logic         hb_lock
);

    localparam logic [2:0] PT_HB   = 3'b000;
    localparam logic [2:0] PT_CH   = 3'b001;
    localparam logic [2:0] PT_TS   = 3'b100;
    localparam logic [2:0] PT_DATA = 3'b101;

    localparam int              HCW      = $clog2(HB_TIMEOUT + 1);
    localparam logic [HCW-1:0]  HB_LAST  = HCW'(HB_TIMEOUT - 1);
    localparam int              CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(W - 1);

    typedef enum logic {UNLOCKED, LOCKED} lock_t;
    typedef enum logic [1:0] {IDLE, DIV, DONE} div_t;

    lock_t          lock_state, lock_next;
    div_t           div_state, div_next;
    logic [HCW-1:0] hb_cnt;
    logic [W-1:0]   e_max_r, e_min_r, e_thr_r;
    logic [W-1:0]   hop_inc;
    logic           hb_ev, ch_ev, ts_ev, data_ev;

    logic [W-1:0]   num_raw, num_calc, den_calc;
    logic [W-1:0]   rem, den_r, quo, rem_nxt, quo_nxt;
    logic [W:0]     rem_sh;
    logic           sub_ok;
    logic [CW-1:0]  bit_cnt;

    assign my_node_id = NODE_ID;
    assign hb_ev   = en_i && (pkt_type == PT_HB);
    assign ch_ev   = en_i && (pkt_type == PT_CH);
    assign ts_ev   = en_i && (pkt_type == PT_TS);
    assign data_ev = en_i && (pkt_type == PT_DATA);
    assign hop_inc = (&hops) ? hops : hops + W'(1);
    assign hb_lock = (lock_state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lock_state <= UNLOCKED;
        else     lock_state <= lock_next;
    end

    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            UNLOCKED: if (hb_ev) lock_next = LOCKED;
            LOCKED:   if (data_ev || hb_cnt == HB_LAST) lock_next = UNLOCKED;
            default:  lock_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt         <= '0;
            hops_from_sink <= '1;
            e_max_r        <= '0;
            e_min_r        <= '0;
            e_thr_r        <= '0;
            timeslot_o     <= '0;
        end else begin
            hb_cnt <= (lock_state == LOCKED && lock_next == LOCKED) ? hb_cnt + HCW'(1) : '0;
            if (hb_ev) begin
                if (lock_state == UNLOCKED) begin
                    e_max_r        <= e_max;
                    e_min_r        <= e_min;
                    e_thr_r        <= e_threshold;
                    hops_from_sink <= hop_inc;
                end else if (hop_inc < hops_from_sink) begin
                    hops_from_sink <= hop_inc;
                end
            end
            if (ts_ev) timeslot_o <= timeslot;
        end
    end

    // Clear level is computed one bit wider so threshold+HYST cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_e <= 1'b0;
        end else if (energy < e_thr_r) begin
            low_e <= 1'b1;
        end else if ({1'b0, energy} >= ({1'b0, e_thr_r} + {1'b0, HYST})) begin
            low_e <= 1'b0;
        end
    end

`ifdef NODEINFO_ROLE_TIMEOUT_EN
    localparam int             RCW       = $clog2(ROLE_TIMEOUT + 1);
    localparam logic [RCW-1:0] ROLE_LAST = RCW'(ROLE_TIMEOUT - 1);
    logic [RCW-1:0] role_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            role     <= 1'b0;
            role_cnt <= '0;
        end else if (ch_ev) begin
            role     <= (ch_id == NODE_ID);
            role_cnt <= '0;
        end else if (role) begin
            if (role_cnt == ROLE_LAST) begin
                role     <= 1'b0;
                role_cnt <= '0;
            end else begin
                role_cnt <= role_cnt + RCW'(1);
            end
        end else begin
            role_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        role <= 1'b0;
        else if (ch_ev) role <= (ch_id == NODE_ID);
    end
`endif

    always_comb begin
        den_calc = (e_max_r > e_min_r) ? e_max_r - e_min_r : '0;
        num_raw  = (energy > e_min_r) ? energy - e_min_r : '0;
        num_calc = (num_raw > den_calc) ? den_calc : num_raw;
        rem_sh   = {rem, 1'b0};
        sub_ok   = (rem_sh >= {1'b0, den_r});
        rem_nxt  = sub_ok ? W'(rem_sh - {1'b0, den_r}) : rem_sh[W-1:0];
        quo_nxt  = {quo[W-2:0], sub_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_state <= IDLE;
        else     div_state <= div_next;
    end

    always_comb begin
        div_next = div_state;
        q_busy   = 1'b0;
        q_valid  = 1'b0;
        case (div_state)
            IDLE: if (q_start) div_next = (den_calc == '0) ? DONE : DIV;
            DIV: begin
                q_busy = 1'b1;
                if (bit_cnt == BIT_LAST) div_next = DONE;
            end
            DONE: begin
                q_valid  = 1'b1;
                div_next = IDLE;
            end
            default: div_next = IDLE;
        endcase
    end

    // With num == den every step subtracts exactly den, so the quotient is all-ones without a clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem        <= '0;
            den_r      <= '0;
            quo        <= '0;
            bit_cnt    <= '0;
            my_q_value <= '0;
        end else begin
            case (div_state)
                IDLE: if (q_start) begin
                    rem     <= num_calc;
                    den_r   <= den_calc;
                    quo     <= '0;
                    bit_cnt <= '0;
                    if (den_calc == '0) my_q_value <= '1;
                end
                DIV: begin
                    rem     <= rem_nxt;
                    quo     <= quo_nxt;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == BIT_LAST) my_q_value <= quo_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_node_info_ctrl.sv
// Self-checking bench for node_info_ctrl; Q results go through an expected-value queue.
module tb_node_info_ctrl;

    logic        clk, rst, en_i, q_start;
    logic [2:0]  pkt_type;
    logic [15:0] e_max, e_min, e_threshold, energy, ch_id, hops, timeslot;
    logic [15:0] my_node_id, hops_from_sink, timeslot_o, my_q_value;
    logic        q_busy, q_valid, role, low_e, hb_lock;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_exp[$];
    int unsigned m_emax, m_emin;

    node_info_ctrl #(.W(16), .NODE_ID(16'h000C), .HYST(16'd8), .HB_TIMEOUT(1024), .ROLE_TIMEOUT(4096)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .pkt_type(pkt_type), .e_max(e_max), .e_min(e_min),
        .e_threshold(e_threshold), .energy(energy), .ch_id(ch_id), .hops(hops), .timeslot(timeslot),
        .q_start(q_start), .my_node_id(my_node_id), .hops_from_sink(hops_from_sink),
        .timeslot_o(timeslot_o), .my_q_value(my_q_value), .q_busy(q_busy), .q_valid(q_valid),
        .role(role), .low_e(low_e), .hb_lock(hb_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] model_q(input int unsigned e, input int unsigned emx, input int unsigned emn);
        longint unsigned num, den, r;
        if (emx <= emn) return 16'hFFFF;
        den = emx - emn;
        num = (e > emn) ? e - emn : 0;
        if (num > den) num = den;
        r = (num << 16) / den;
        if (r > 65535) r = 65535;
        return 16'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [2:0] t);
        pkt_type = t;
        en_i = 1'b1;
        tick();
        en_i = 1'b0;
        pkt_type = 3'b111;
    endtask

    task automatic send_hb(input logic [15:0] h, input logic [15:0] mx, input logic [15:0] mn, input logic [15:0] th);
        hops = h; e_max = mx; e_min = mn; e_threshold = th;
        send_pkt(3'b000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (hops_from_sink !== 16'hFFFF) begin errors++; $display("FAIL reset_hops got %h exp ffff", hops_from_sink); end
        checks++; if ({timeslot_o, my_q_value} !== 32'h0) begin errors++; $display("FAIL reset_words got %h %h exp 0", timeslot_o, my_q_value); end
        checks++; if ({q_busy, q_valid, role, low_e, hb_lock} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {q_busy, q_valid, role, low_e, hb_lock}); end
        checks++; if (my_node_id !== 16'h000C) begin errors++; $display("FAIL node_id got %h exp 000c", my_node_id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hb();
        energy = 16'd600;
        send_hb(16'd3, 16'd1000, 16'd200, 16'd300);
        m_emax = 1000; m_emin = 200;
        checks++; if (hops_from_sink !== 16'd4) begin errors++; $display("FAIL hb_first_hops got %0d exp 4", hops_from_sink); end
        checks++; if (hb_lock !== 1'b1) begin errors++; $display("FAIL hb_lock_set got %b exp 1", hb_lock); end
        send_hb(16'd5, 16'd1000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'd4) begin errors++; $display("FAIL hb_worse_route got %0d exp 4", hops_from_sink); end
        send_hb(16'd1, 16'd2000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'd2) begin errors++; $display("FAIL hb_better_route got %0d exp 2", hops_from_sink); end
    endtask

    task automatic test_q();
        int unsigned tbl[5] = '{600, 100, 1000, 400, 201};
        int cyc, busy;
        logic [15:0] exp_q;
        for (int i = 0; i < 5; i++) begin
            energy = 16'(tbl[i]);
            q_start = 1'b1;
            q_exp.push_back(model_q(tbl[i], m_emax, m_emin));
            tick();
            q_start = 1'b0;
            cyc = 1; busy = 0;
            while (q_valid !== 1'b1 && cyc < 40) begin
                if (q_busy === 1'b1) busy++;
                tick(); cyc++;
            end
            checks++; if (cyc != 17) begin errors++; $display("FAIL q_latency e=%0d got %0d exp 17", tbl[i], cyc); end
            checks++; if (busy != 16) begin errors++; $display("FAIL q_busy_cycles e=%0d got %0d exp 16", tbl[i], busy); end
            exp_q = (q_exp.size() != 0) ? q_exp.pop_front() : 16'hxxxx;
            checks++; if (my_q_value !== exp_q) begin errors++; $display("FAIL q_value e=%0d got %h exp %h", tbl[i], my_q_value, exp_q); end
            tick();
            checks++; if (q_valid !== 1'b0 || q_busy !== 1'b0) begin errors++; $display("FAIL q_pulse e=%0d got valid=%b busy=%b exp 0 0", tbl[i], q_valid, q_busy); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, pulses;
        logic [15:0] exp_q;
        energy = 16'd600;
        q_start = 1'b1;
        q_exp.push_back(model_q(600, m_emax, m_emin));
        tick();
        energy = 16'd100;
        tick();
        q_start = 1'b0;
        cyc = 2;
        while (q_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        exp_q = (q_exp.size() != 0) ? q_exp.pop_front() : 16'hxxxx;
        checks++; if (my_q_value !== exp_q) begin errors++; $display("FAIL q_operand_hold got %h exp %h", my_q_value, exp_q); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (q_valid === 1'b1) pulses++; end
        checks++; if (pulses != 0) begin errors++; $display("FAIL q_start_ignored got %0d extra pulses exp 0", pulses); end
        energy = 16'd400;
        q_start = 1'b1;
        q_exp.push_back(model_q(400, m_emax, m_emin));
        tick();
        q_start = 1'b0;
        cyc = 1;
        while (q_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        exp_q = (q_exp.size() != 0) ? q_exp.pop_front() : 16'hxxxx;
        checks++; if (my_q_value !== exp_q || cyc != 17) begin errors++; $display("FAIL q_second got %h at %0d exp %h at 17", my_q_value, cyc, exp_q); end
    endtask

    task automatic test_lock_data();
        send_pkt(3'b101);
        checks++; if (hb_lock !== 1'b0) begin errors++; $display("FAIL data_unlock got %b exp 0", hb_lock); end
        send_hb(16'd3, 16'd1000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'd4 || hb_lock !== 1'b1) begin errors++; $display("FAIL relock got hops=%0d lock=%b exp 4 1", hops_from_sink, hb_lock); end
        repeat (9) tick();
        checks++; if (hb_lock !== 1'b1) begin errors++; $display("FAIL lock_before_data got %b exp 1", hb_lock); end
        send_pkt(3'b101);
        checks++; if (hb_lock !== 1'b0) begin errors++; $display("FAIL data_cycle11 got %b exp 0", hb_lock); end
    endtask

    task automatic test_lock_timeout();
        int n;
        send_hb(16'd7, 16'd1000, 16'd200, 16'd300);
        n = 0;
        while (hb_lock === 1'b1 && n < 2000) begin n++; tick(); end
        checks++; if (n != 1024) begin errors++; $display("FAIL hb_timeout got %0d locked cycles exp 1024", n); end
        checks++; if (hops_from_sink !== 16'd8) begin errors++; $display("FAIL timeout_hops got %0d exp 8", hops_from_sink); end
    endtask

    task automatic test_hops_sat();
        send_hb(16'hFFFF, 16'd1000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'hFFFF) begin errors++; $display("FAIL hops_sat got %h exp ffff", hops_from_sink); end
        send_hb(16'hFFFE, 16'd1000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'hFFFF) begin errors++; $display("FAIL hops_sat_edge got %h exp ffff", hops_from_sink); end
        send_hb(16'h0000, 16'd1000, 16'd200, 16'd300);
        checks++; if (hops_from_sink !== 16'd1) begin errors++; $display("FAIL hops_zero got %h exp 0001", hops_from_sink); end
        send_pkt(3'b101);
    endtask

    task automatic test_q_den_zero();
        int cyc, busy;
        logic [15:0] exp_q;
        send_hb(16'd3, 16'd500, 16'd500, 16'd300);
        m_emax = 500; m_emin = 500;
        energy = 16'd600;
        q_start = 1'b1;
        q_exp.push_back(model_q(600, m_emax, m_emin));
        tick();
        q_start = 1'b0;
        cyc = 1; busy = 0;
        while (q_valid !== 1'b1 && cyc < 40) begin
            if (q_busy === 1'b1) busy++;
            tick(); cyc++;
        end
        checks++; if (cyc != 1 || busy != 0) begin errors++; $display("FAIL den0_latency got %0d busy %0d exp 1 busy 0", cyc, busy); end
        exp_q = (q_exp.size() != 0) ? q_exp.pop_front() : 16'hxxxx;
        checks++; if (my_q_value !== exp_q) begin errors++; $display("FAIL den0_value got %h exp %h", my_q_value, exp_q); end
    endtask

    task automatic test_low_e();
        int unsigned e_tbl[7] = '{299, 305, 307, 308, 300, 299, 400};
        logic        l_tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            energy = 16'(e_tbl[i]);
            tick();
            checks++; if (low_e !== l_tbl[i]) begin errors++; $display("FAIL low_e e=%0d got %b exp %b", e_tbl[i], low_e, l_tbl[i]); end
        end
    endtask

    task automatic test_role();
        int n;
        ch_id = 16'h000C; send_pkt(3'b001);
        checks++; if (role !== 1'b1) begin errors++; $display("FAIL role_self got %b exp 1", role); end
        ch_id = 16'h0007; send_pkt(3'b010);
        checks++; if (role !== 1'b1) begin errors++; $display("FAIL role_ignored_type got %b exp 1", role); end
        send_pkt(3'b001);
        checks++; if (role !== 1'b0) begin errors++; $display("FAIL role_other got %b exp 0", role); end
        timeslot = 16'h1234; send_pkt(3'b100);
        checks++; if (timeslot_o !== 16'h1234) begin errors++; $display("FAIL timeslot got %h exp 1234", timeslot_o); end
        ch_id = 16'h000C; send_pkt(3'b001);
        n = 0;
`ifdef NODEINFO_ROLE_TIMEOUT_EN
        while (role === 1'b1 && n < 5000) begin n++; tick(); end
        checks++; if (n != 4096) begin errors++; $display("FAIL role_timeout got %0d cycles exp 4096", n); end
`else
        while (role === 1'b1 && n < 200) begin n++; tick(); end
        checks++; if (n != 200) begin errors++; $display("FAIL role_hold got %0d cycles exp 200", n); end
`endif
    endtask

    task automatic test_reset_abort();
        int pulses;
        send_pkt(3'b101);
        send_hb(16'd3, 16'd1000, 16'd200, 16'd300);
        energy = 16'd600;
        q_start = 1'b1;
        tick();
        q_start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (my_q_value !== 16'h0 || q_busy !== 1'b0) begin errors++; $display("FAIL abort_q got %h busy %b exp 0000 0", my_q_value, q_busy); end
        checks++; if (hops_from_sink !== 16'hFFFF || hb_lock !== 1'b0) begin errors++; $display("FAIL abort_state got hops=%h lock=%b exp ffff 0", hops_from_sink, hb_lock); end
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (q_valid === 1'b1) pulses++; end
        checks++; if (pulses != 0 || my_q_value !== 16'h0) begin errors++; $display("FAIL abort_no_valid got %0d pulses q=%h exp 0 0000", pulses, my_q_value); end
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", q_exp.size()); end
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; q_start = 1'b0; pkt_type = 3'b111;
        e_max = '0; e_min = '0; e_threshold = '0; energy = '0; ch_id = '0; hops = '0; timeslot = '0;
        m_emax = 0; m_emin = 0;
        test_reset();
        test_hb();
        test_q();
        test_back_to_back();
        test_lock_data();
        test_lock_timeout();
        test_hops_sat();
        test_q_den_zero();
        test_low_e();
        test_role();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/node_info_ctrl.md
Name:
node_info_ctrl

Overview:
Parametrised next-generation node-state block for the EER-RL clustered WSN node. It holds the node's hop count, cluster role, TDMA timeslot and heartbeat lock, and keeps a low-energy flag with hysteresis. It also computes the node's Q-value as normalised residual energy, using a multi-cycle restoring divider with a start/busy/valid handshake. It sits between the packet filter (which supplies the packet type and fields) and the routing/CH-election logic.

Parameters:
W, 16, data word width for energy, hops, IDs, timeslot and Q.
NODE_ID, 16'h000C, this node's ID, a constant driven on my_node_id.
HYST, 16'd8, low-energy clear hysteresis in energy units.
HB_TIMEOUT, 1024, cycles in LOCKED with no DATA packet before the lock auto-releases.
ROLE_TIMEOUT, 4096, cycles a CH role survives without re-announce (optional feature only).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en_i  in  1  packet-field valid strobe from the filter
pkt_type  in  3  000 HB, 001 CH announce, 100 timeslot, 101 DATA, others ignored
e_max  in  W  network max energy (HB field)
e_min  in  W  network min energy (HB field)
e_threshold  in  W  low-energy threshold (HB field)
energy  in  W  own residual energy, sampled every cycle
ch_id  in  W  announced cluster-head ID
hops  in  W  sender's hop count (HB field)
timeslot  in  W  assigned TDMA slot
q_start  in  1  request a Q recompute
my_node_id  out  W  NODE_ID
hops_from_sink  out  W  stored hop count
timeslot_o  out  W  stored timeslot
my_q_value  out  W  last computed Q
q_busy  out  1  divider running
q_valid  out  1  one-cycle pulse when my_q_value updates
role  out  1  1 = cluster head
low_e  out  1  low-energy flag
hb_lock  out  1  1 = LOCKED

Behaviour:
- Reset (asynchronous, active-high): every register and output goes to 0, except hops_from_sink, which resets to all-ones (unknown route). The lock FSM resets to UNLOCKED and the divider FSM to IDLE.
- A packet event is en_i=1 in a cycle. Fields are registered on the same clock edge, so outputs update 1 cycle later.
- Lock FSM, UNLOCKED:
  - An HB event captures e_max, e_min and e_threshold, sets hops_from_sink = sat(hops+1), moves to LOCKED and clears the timeout counter.
- Lock FSM, LOCKED:
  - An HB event does not change e_max, e_min or e_threshold.
  - If sat(hops+1) < hops_from_sink, hops_from_sink is updated (better route).
  - A DATA event moves to UNLOCKED.
  - When the timeout counter reaches HB_TIMEOUT-1, the FSM moves to UNLOCKED.
  - If DATA and timeout occur in the same cycle, the result is UNLOCKED.
  - The counter runs only in LOCKED.
- sat(x) saturates at 2^W-1. hops = all-ones therefore stays all-ones.
- CH event: role = (ch_id == NODE_ID), latched.
- Timeslot event: timeslot_o = timeslot.
- Only one pkt_type exists per cycle, so events never collide.
- low_e:
  - Set when energy < e_threshold (the captured value).
  - Cleared only when energy >= e_threshold + HYST. The addition uses W+1 bits and is compared unsaturated.
  - Otherwise low_e holds.
- Q divider, IDLE:
  - q_start=1 snapshots the operands:
    - num = clamp(energy - e_min, 0, den).
    - den = e_max - e_min; if e_max <= e_min, den = 0.
  - The FSM moves to DIV and q_busy goes to 1.
  - q_start while busy is ignored (no queueing).
- Q divider, DIV:
  - Performs a W-iteration restoring division of num·2^W by den, one bit per cycle.
  - It then moves to DONE.
- Q divider, DONE:
  - my_q_value = quotient, saturated to 2^W-1 (num == den gives all-ones).
  - q_valid pulses for 1 cycle, q_busy goes to 0, and the FSM returns to IDLE.
- If den == 0, DIV is skipped: IDLE → DONE directly with result all-ones.
- Latency: q_start at cycle 0 gives q_valid at cycle W+1 (normal case) or at cycle 1 (den == 0).
- Operand changes during DIV do not affect the result.
- Reset mid-division aborts it: my_q_value = 0 and no q_valid pulse.

Optional Feature:
Macro: NODEINFO_ROLE_TIMEOUT_EN.
- Defined: a role counter runs while role=1. It clears on every CH event with ch_id == NODE_ID. When it reaches ROLE_TIMEOUT-1, role drops to 0.
- Not defined: role is held until the next CH event, and ROLE_TIMEOUT is unused.

Test Plan:
- Reset → hops_from_sink=16'hFFFF; all other outputs 0; hb_lock=0.
- HB with hops=3, e_max=1000, e_min=200, e_threshold=300 → hops_from_sink=4 and hb_lock=1 one cycle later. A second HB with hops=5 leaves hops_from_sink=4. A third HB with hops=1 gives hops_from_sink=2, and e_max stays 1000 even if the HB carries 2000.
- In LOCKED with no DATA for 1024 cycles → hb_lock drops at exactly cycle 1024. Repeat, sending DATA at cycle 10 → hb_lock=0 at cycle 11.
- energy=600 (after HB e_min=200, e_max=1000), q_start → q_busy for 16 cycles, q_valid at cycle 17, my_q_value=16'h8000. energy=100 gives 0. energy=1000 gives 16'hFFFF. Capturing e_max=e_min=500 first, then q_start, gives 16'hFFFF at cycle 1.
- e_threshold=300, HYST=8: energy 299 → low_e=1; 305 → low_e stays 1; 308 → low_e=0.
- CH announce ch_id=16'h000C → role=1; ch_id=16'h0007 → role=0. With NODEINFO_ROLE_TIMEOUT_EN defined and no re-announce, role=0 after 4096 cycles.
